ps2_key_event_queue: RTL and testbench

- Parametrised successor to the keyboard decoder. Consumes the raw PS/2 byte stream from the keyboard controller and parses the E0/F0 prefixes itself.
- Maintains a 512-bit key-down bitmap, optionally suppresses typematic repeats, and queues make/break events in a FIFO with valid/ready.
- Sits between the PS/2 controller and game logic, so no key press or release is lost while the consumer is busy.

---
 rtl/ps2_key_event_queue_if.sv | 14 +
 rtl/ps2_key_event_queue.sv | 116 +++++++++++
 tb/tb_ps2_key_event_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_queue_if.sv
// ps2_key_event_queue_if: scancode byte input and make/break event output of the key event queue
// master: byte source and event consumer (drives byte_*, evt_ready)
// slave:  the queue (drives evt_valid, evt_code, evt_break)
interface ps2_key_event_queue_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic       evt_break;
  modport master(output byte_valid, byte_data, byte_err, evt_ready, input evt_valid, evt_code, evt_break);
  modport slave(input byte_valid, byte_data, byte_err, evt_ready, output evt_valid, evt_code, evt_break);
endinterface

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: PS/2 scancode parser with 512-bit key-down bitmap and make/break event FIFO
// clk, rst_n (async active-low); bus: byte stream in, events out (valid/ready);
// clear: sync flush of bitmap/FIFO/overflow; key_down, kbd_ready, fifo_count, overflow: status
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_REPEAT  = 1,
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int REQUIRE_BAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ps2_key_event_queue_if.slave        bus,
  input  logic                        clear,
  output logic [511:0]                key_down,
  output logic                        kbd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  typedef enum logic [2:0] {INIT, WAIT_BYTE, PRE_E0, PRE_F0, PRE_E0F0} state_t;
  state_t        st_q, st_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          kbd_q, kbd_d;
  logic [511:0]  kd_q, kd_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          cm, brk, wipe, push, pop, full, wr_en, junk;
  logic [8:0]    code;
  assign junk = bus.byte_data inside {8'h00, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'hFF};
  always_comb begin
    st_d  = st_q;
    tmo_d = tmo_q;
    kbd_d = kbd_q;
    cm    = 1'b0;
    brk   = 1'b0;
    wipe  = 1'b0;
    code  = {st_q == PRE_E0 || st_q == PRE_E0F0, bus.byte_data};
    if (bus.byte_err) begin
      tmo_d = '0;
      st_d  = st_q == INIT ? INIT : WAIT_BYTE;
    end else if (bus.byte_valid) begin
      tmo_d = '0;
      case (st_q)
        INIT: begin
          kbd_d = kbd_q || bus.byte_data == 8'hAA;
          st_d  = bus.byte_data == 8'hAA ? WAIT_BYTE : INIT;
        end
        WAIT_BYTE: begin
          st_d = bus.byte_data == 8'hE0 ? PRE_E0 : bus.byte_data == 8'hF0 ? PRE_F0 : WAIT_BYTE;
          wipe = bus.byte_data == 8'hAA;
          cm   = st_d == WAIT_BYTE && !wipe && !junk;
        end
        PRE_E0: begin
          st_d = bus.byte_data == 8'hF0 ? PRE_E0F0 : bus.byte_data == 8'hE0 ? PRE_E0 : WAIT_BYTE;
          cm   = st_d == WAIT_BYTE;
        end
        PRE_F0, PRE_E0F0: begin
          st_d = WAIT_BYTE;
          cm   = 1'b1;
          brk  = 1'b1;
        end
        default: st_d = WAIT_BYTE;
      endcase
    end else if (st_q != INIT && st_q != WAIT_BYTE) begin
      tmo_d = tmo_q == TW'(PREFIX_TIMEOUT - 1) ? '0 : tmo_q + TW'(1);
      st_d  = tmo_q == TW'(PREFIX_TIMEOUT - 1) ? WAIT_BYTE : st_q;
    end
    // repeat filter: a make for a held key or a break for a released key is a no-op
    push = cm && !(FILTER_REPEAT != 0 && kd_q[code] == !brk);
  end
  always_comb begin
    kd_d = kd_q;
    if (push) kd_d[code] = !brk;
    if (wipe || clear) kd_d = '0;
    pop   = cnt_q != '0 && bus.evt_ready;
    full  = cnt_q == CW'(FIFO_DEPTH);
    wr_en = push && (!full || pop);
    wr_d  = clear ? '0 : wr_q + AW'(wr_en);
    rd_d  = clear ? '0 : rd_q + AW'(pop);
    cnt_d = clear ? '0 : cnt_q + CW'(wr_en) - CW'(pop);
    ovf_d = !clear && (ovf_q || (push && !wr_en));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= REQUIRE_BAT != 0 ? INIT : WAIT_BYTE;
      tmo_q <= '0;
      kbd_q <= REQUIRE_BAT == 0;
      kd_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      st_q  <= st_d;
      tmo_q <= tmo_d;
      kbd_q <= kbd_d;
      kd_q  <= kd_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (wr_en && !clear) mem_q[wr_q] <= {code, brk};
    end
  end
  assign key_down      = kd_q;
  assign kbd_ready     = kbd_q;
  assign fifo_count    = cnt_q;
  assign overflow      = ovf_q;
  assign bus.evt_valid = cnt_q != '0;
  assign {bus.evt_code, bus.evt_break} = mem_q[rd_q];
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb_ps2_key_event_queue: directed checks of parsing, filtering, FIFO, timeout and clear
module tb_ps2_key_event_queue;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bv = 1'b0, be = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [7:0]   bd = 8'h00;
  logic [511:0] kd0, kd1;
  logic         kr0, kr1, ov0, ov1;
  logic [2:0]   fc0;
  logic [3:0]   fc1;
  int           total = 0, bad = 0;
  ps2_key_event_queue_if if0();
  ps2_key_event_queue_if if1();
  assign if0.byte_valid = bv;
  assign if0.byte_data  = bd;
  assign if0.byte_err   = be;
  assign if0.evt_ready  = rdy;
  assign if1.byte_valid = bv;
  assign if1.byte_data  = bd;
  assign if1.byte_err   = be;
  assign if1.evt_ready  = rdy;
  ps2_key_event_queue #(.FIFO_DEPTH(4), .FILTER_REPEAT(1), .PREFIX_TIMEOUT(10), .REQUIRE_BAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .clear(clr),
    .key_down(kd0), .kbd_ready(kr0), .fifo_count(fc0), .overflow(ov0));
  ps2_key_event_queue #(.FIFO_DEPTH(8), .FILTER_REPEAT(0), .PREFIX_TIMEOUT(10), .REQUIRE_BAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .clear(clr),
    .key_down(kd1), .kbd_ready(kr1), .fifo_count(fc1), .overflow(ov1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bv = 1'b1;
    bd = b;
    @(negedge clk);
    bv = 1'b0;
  endtask
  task automatic pop0(input string tag, input logic [8:0] c, input logic b);
    chk({tag, "_valid"}, 32'(if0.evt_valid), 1);
    chk({tag, "_code"}, 32'(if0.evt_code), 32'(c));
    chk({tag, "_break"}, 32'(if0.evt_break), 32'(b));
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask
  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 32'(kr0), 0);
    chk("rst_ready1", 32'(kr1), 1);
    chk("rst_valid", 32'(if0.evt_valid), 0);
    chk("rst_count", 32'(fc0), 0);
    chk("rst_ovf", 32'(ov0), 0);
    chk("rst_kd", 32'(|kd0), 0);
    send(8'h1C);
    chk("prebat_count", 32'(fc0), 0);
    chk("prebat_ready", 32'(kr0), 0);
    send(8'hAA);
    chk("bat_ready", 32'(kr0), 1);
    send(8'h1C);
    chk("make_count", 32'(fc0), 1);
    chk("make_kd", 32'(kd0[9'h01C]), 1);
    chk("nobat_count", 32'(fc1), 2);
    pop0("make1c", 9'h01C, 1'b0);
    chk("pop_count", 32'(fc0), 0);
    pulse_clear();
    chk("clr_kd", 32'(|kd0), 0);
    chk("clr_ready", 32'(kr0), 1);
    send(8'hE0);
    send(8'h75);
    chk("ext_kd_make", 32'(kd0[9'h175]), 1);
    pop0("ext_make", 9'h175, 1'b0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_kd_break", 32'(kd0[9'h175]), 0);
    pop0("ext_break", 9'h175, 1'b1);
    pulse_clear();
    send(8'h1D);
    send(8'h1D);
    send(8'h1D);
    send(8'hF0);
    send(8'h1D);
    send(8'hF0);
    send(8'h1D);
    chk("filt_count", 32'(fc0), 2);
    chk("nofilt_count", 32'(fc1), 5);
    pop0("filt_make", 9'h01D, 1'b0);
    pop0("filt_break", 9'h01D, 1'b1);
    chk("filt_empty", 32'(fc0), 0);
    chk("nofilt_left", 32'(fc1), 3);
    chk("nofilt_head", 32'({if1.evt_code, if1.evt_break}), 32'({9'h01D, 1'b0}));
    pulse_clear();
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    chk("ovf_count", 32'(fc0), 4);
    chk("ovf_flag", 32'(ov0), 1);
    chk("ovf_kd", 32'(kd0[9'h018:9'h010]), 32'h1FF);
    for (int i = 0; i < 4; i++) pop0($sformatf("ovf_pop%0d", i), 9'(9'h010 + i), 1'b0);
    chk("ovf_sticky", 32'(ov0), 1);
    pulse_clear();
    chk("clr_ovf", 32'(ov0), 0);
    send(8'hE0);
    repeat (9) @(negedge clk);
    send(8'h75);
    pop0("tmo_edge", 9'h175, 1'b0);
    send(8'hE0);
    repeat (10) @(negedge clk);
    send(8'h6B);
    pop0("tmo_drop", 9'h06B, 1'b0);
    pulse_clear();
    send(8'hF0);
    be = 1'b1;
    @(negedge clk);
    be = 1'b0;
    send(8'h6B);
    chk("err_count", 32'(fc0), 1);
    pop0("err_make", 9'h06B, 1'b0);
    pulse_clear();
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
    rdy = 1'b1;
    bv = 1'b1;
    bd = 8'h24;
    @(negedge clk);
    rdy = 1'b0;
    bv = 1'b0;
    chk("full_pp_count", 32'(fc0), 4);
    chk("full_pp_ovf", 32'(ov0), 0);
    for (int i = 1; i < 4; i++) pop0($sformatf("full_pop%0d", i), 9'(9'h020 + i), 1'b0);
    chk("full_last", 32'({if0.evt_code, if0.evt_break}), 32'({9'h024, 1'b0}));
    chk("full_kd24", 32'(kd0[9'h024]), 1);
    pulse_clear();
    chk("final_clr_count", 32'(fc0), 0);
    chk("final_clr_kd", 32'(|kd0), 0);
    send(8'h30);
    send(8'hE0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(fc0), 0);
    chk("mid_rst_ready", 32'(kr0), 0);
    send(8'hAA);
    send(8'h75);
    pop0("mid_rst_make", 9'h075, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
